regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the integer register file: NRD combinational read ports, one write port with write-through bypass, register 0 hard-wired to zero.
- Adds a per-register busy scoreboard: decode marks a destination pending at issue, and writeback clears it.
- Exposes per-port busy/hazard flags and a flush, so decode can stall on RAW hazards without its own tracking.
- Sits between decode (read and issue side) and execute/writeback (write side).

Parameters:
- DW, 32, data width of each register.
- NREG, 32, number of registers. Must be a power of 2 and at least 2.
- NRD, 2, number of read ports, 1 to 4.
- AW, $clog2(NREG), address width. Derived localparam; not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- rd_addr_i  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data_o  out  NRD*DW  read data; port k occupies bits [k*DW +: DW].
- rd_busy_o  out  NRD  port k's register has a pending write not yet satisfied.
- wr_en_i  in  1  writeback enable.
- wr_addr_i  in  AW  writeback address.
- wr_data_i  in  DW  writeback data.
- iss_en_i  in  1  request to mark iss_addr_i pending.
- iss_addr_i  in  AW  destination register being issued.
- iss_ready_o  out  1  issue is accepted this cycle.
- flush_i  in  1  clear all busy bits (pipeline flush).
- busy_vec_o  out  NREG  raw scoreboard state; bit 0 is always 0.

Behaviour:
- Reset (rst low, asynchronous):
  - All NREG registers are cleared to 0, including the top register.
  - All busy bits are cleared.
  - While rst is low: rd_data_o = 0, rd_busy_o = 0, iss_ready_o = 0, busy_vec_o = 0.
- Read (combinational, zero latency), per port k with address a:
  - a == 0: data 0, busy 0.
  - else if wr_en_i and wr_addr_i == a: data = wr_data_i (bypass), busy 0 (the write satisfies the hazard).
  - else: data = regs[a], busy = busy[a].
- Write:
  - On posedge clk, if wr_en_i and wr_addr_i != 0: regs[wr_addr_i] <= wr_data_i.
  - Writes to address 0 are discarded.
- Issue:
  - iss_ready_o = rst & (iss_addr_i == 0 | !busy[iss_addr_i] | (wr_en_i & wr_addr_i == iss_addr_i)).
  - This allows at most one outstanding write per register, except where the same-cycle writeback clears it.
  - Issue is accepted when iss_en_i & iss_ready_o. On acceptance with iss_addr_i != 0, busy[iss_addr_i] is set next cycle.
  - A rejected issue changes nothing; the requester holds and retries.
- Busy update, per register r != 0, evaluated each posedge in priority order:
  1. flush_i: busy[r] <= 0. Issue is ignored in that cycle; the write still commits.
  2. Accepted issue to r: busy[r] <= 1. Set wins over a same-cycle clear.
  3. wr_en_i & wr_addr_i == r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- A write to a register that is not busy is legal: data updates, busy stays 0.
- Reset asserted mid-operation: state clears immediately. Pending scoreboard entries are lost, and the owner must flush the pipeline.

Optional Feature:
- Macro REGFILE_SB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o, width 32.
  - Increments by 1 on each posedge where any rd_busy_o bit is 1, or where iss_en_i & !iss_ready_o.
  - Saturates at 32'hFFFF_FFFF.
  - Reset value 0. Not cleared by flush_i.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset and zero register:
  - Stimulus: hold rst low with wr_en_i=1, wr_addr_i=5, wr_data_i=32'hDEAD; release rst; read port0 at 5.
  - Required: read returns 0.
  - Stimulus: write 32'h1234 to reg 0.
  - Required: read of 0 returns 0 and busy_vec_o[0] stays 0.
- Top register:
  - Stimulus: write 32'hA5A5_A5A5 to reg NREG-1, then assert reset.
  - Required: read of NREG-1 returns 0.
- Bypass:
  - Stimulus: wr_en_i=1, wr_addr_i=3, wr_data_i=32'h55, with port0 and port1 both reading 3 in the same cycle.
  - Required: both ports return 32'h55 with busy 0; next cycle regs[3] = 32'h55.
- Scoreboard:
  - Stimulus: issue reg 7.
  - Required: next cycle busy_vec_o[7]=1; a read of 7 gives rd_busy_o=1.
  - Stimulus: second issue of 7.
  - Required: iss_ready_o=0.
  - Stimulus: writeback 7 with 32'h99.
  - Required: same cycle rd_busy_o=0 and data=32'h99; next cycle busy_vec_o[7]=0.
- Simultaneous set/clear:
  - Stimulus: busy[4]=1; in one cycle writeback 4 and issue 4.
  - Required: iss_ready_o=1; next cycle busy[4]=1 and regs[4] holds the written value.
- Flush priority:
  - Stimulus: busy on regs 2, 9, 17; assert flush_i together with an issue of 11.
  - Required: next cycle busy_vec_o=0.
  - With REGFILE_SB_STALL_CNT_EN: 3 cycles of a rejected issue raise stall_cnt_o from 0 to 3.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with write-through bypass, hard-wired zero register and a per-register busy scoreboard.
// Define REGFILE_SB_STALL_CNT_EN to add the saturating 32-bit stall counter output stall_cnt_o.
module regfile_sb #(
    parameter  int DW   = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD*DW-1:0] rd_data_o,
    output logic [NRD-1:0]    rd_busy_o,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DW-1:0]     wr_data_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_addr_i,
    output logic              iss_ready_o,
    input  logic              flush_i,
`ifdef REGFILE_SB_STALL_CNT_EN
    output logic [31:0]       stall_cnt_o,
`endif
    output logic [NREG-1:0]   busy_vec_o
);

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic            w_issAcc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i != '0)) begin
            r_regs[wr_addr_i] <= wr_data_i;
        end
    end

    // Same-cycle writeback to the issued register releases the old owner, so the new issue may proceed.
    always_comb begin
        iss_ready_o = 1'b0;
        if (rst) begin
            iss_ready_o = (iss_addr_i == '0) || !r_busy[iss_addr_i] ||
                          (wr_en_i && (wr_addr_i == iss_addr_i));
        end
    end

    assign w_issAcc = iss_en_i && iss_ready_o && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int r = 1; r < NREG; r++) begin
                if (flush_i) begin
                    r_busy[r] <= 1'b0;
                end else if (w_issAcc && (iss_addr_i == AW'(r))) begin
                    r_busy[r] <= 1'b1;
                end else if (wr_en_i && (wr_addr_i == AW'(r))) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0] w_ra;
        rd_data_o = '0;
        rd_busy_o = '0;
        w_ra      = '0;
        for (int k = 0; k < NRD; k++) begin
            w_ra = rd_addr_i[k*AW +: AW];
            if (rst && (w_ra != '0)) begin
                if (wr_en_i && (wr_addr_i == w_ra)) begin
                    rd_data_o[k*DW +: DW] = wr_data_i;
                end else begin
                    rd_data_o[k*DW +: DW] = r_regs[w_ra];
                    rd_busy_o[k]          = r_busy[w_ra];
                end
            end
        end
    end

    assign busy_vec_o = rst ? r_busy : '0;

`ifdef REGFILE_SB_STALL_CNT_EN
    logic [31:0] r_stallCnt;
    logic        w_stall;

    assign w_stall = (|rd_busy_o) || (iss_en_i && !iss_ready_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stallCnt <= '0;
        end else if (w_stall && (r_stallCnt != 32'hFFFF_FFFF)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stallCnt;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (default parameters): a vector table stepped one clock per entry,
// followed by hand-written reset and stall-counter sequences.
module tb_regfile_sb;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic              clk;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr_i;
    logic [NRD*DW-1:0] rd_data_o;
    logic [NRD-1:0]    rd_busy_o;
    logic              wr_en_i;
    logic [AW-1:0]     wr_addr_i;
    logic [DW-1:0]     wr_data_i;
    logic              iss_en_i;
    logic [AW-1:0]     iss_addr_i;
    logic              iss_ready_o;
    logic              flush_i;
    logic [NREG-1:0]   busy_vec_o;
`ifdef REGFILE_SB_STALL_CNT_EN
    logic [31:0]       stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    regfile_sb #(.DW(DW), .NREG(NREG), .NRD(NRD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .iss_ready_o(iss_ready_o),
        .flush_i    (flush_i),
`ifdef REGFILE_SB_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .busy_vec_o (busy_vec_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wrEn;
        logic [4:0]  wrAddr;
        logic [31:0] wrData;
        logic        issEn;
        logic [4:0]  issAddr;
        logic        flush;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] expD0;
        logic [31:0] expD1;
        logic [1:0]  expBusy;
        logic        expReady;
        logic [31:0] expVec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic ie, logic [4:0] ia,
                                logic fl, logic [4:0] r0, logic [4:0] r1, logic [31:0] d0,
                                logic [31:0] d1, logic [1:0] b, logic rdy, logic [31:0] bv);
        vec_t v;
        v.wrEn = we; v.wrAddr = wa; v.wrData = wd; v.issEn = ie; v.issAddr = ia; v.flush = fl;
        v.ra0 = r0; v.ra1 = r1; v.expD0 = d0; v.expD1 = d1; v.expBusy = b; v.expReady = rdy;
        v.expVec = bv;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic ie, input logic [4:0] ia, input logic fl,
                                 input logic [4:0] r0, input logic [4:0] r1);
        wr_en_i    = we;
        wr_addr_i  = wa;
        wr_data_i  = wd;
        iss_en_i   = ie;
        iss_addr_i = ia;
        flush_i    = fl;
        rd_addr_i  = {r1, r0};
        #2;
    endtask

    initial begin
        // Outputs reflect pre-edge state plus the combinational bypass; each entry is followed by one clock.
        vecs.push_back(mk(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(1, 3, 32'h55, 0, 0, 0, 3, 3, 32'h55, 32'h55, 2'b00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 3, 32'h55, 32'h55, 2'b00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 7, 0, 7, 3, 0, 32'h55, 2'b00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 7, 0, 7, 7, 0, 0, 2'b11, 0, 32'h80));
        vecs.push_back(mk(1, 7, 32'h99, 0, 0, 0, 7, 3, 32'h99, 32'h55, 2'b00, 1, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 7, 7, 32'h99, 32'h99, 2'b00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4, 0, 4, 0, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(1, 4, 32'h44, 1, 4, 0, 4, 4, 32'h44, 32'h44, 2'b00, 1, 32'h10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4, 4, 32'h44, 32'h44, 2'b11, 1, 32'h10));
        vecs.push_back(mk(1, 4, 32'h45, 0, 0, 0, 4, 4, 32'h45, 32'h45, 2'b00, 1, 32'h10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4, 4, 32'h45, 32'h45, 2'b00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9, 0, 2, 0, 0, 0, 2'b01, 1, 32'h4));
        vecs.push_back(mk(0, 0, 0, 1, 17, 0, 9, 2, 0, 0, 2'b11, 1, 32'h204));
        vecs.push_back(mk(1, 2, 32'h22, 1, 11, 1, 2, 9, 32'h22, 0, 2'b10, 1, 32'h20204));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 11, 2, 0, 32'h22, 2'b00, 1, 0));
        vecs.push_back(mk(1, 31, 32'hA5A5_A5A5, 0, 0, 0, 31, 0, 32'hA5A5_A5A5, 0, 2'b00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 6, 0, 31, 31, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 2'b00, 1, 0));

        // Reset held with a pending write to 5: nothing may leak to the outputs or the array.
        rst = 1'b0;
        applyStimulus(1, 5, 32'hDEAD, 1, 0, 0, 5, 5);
        checkOutput("rst_rd0", 64'(rd_data_o[31:0]), 64'h0);
        checkOutput("rst_ready", 64'(iss_ready_o), 64'h0);
        checkOutput("rst_vec", 64'(busy_vec_o), 64'h0);
        tick();
        tick();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
        checkOutput("post_rst_rd5", 64'(rd_data_o[31:0]), 64'h0);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].wrEn, vecs[i].wrAddr, vecs[i].wrData, vecs[i].issEn,
                          vecs[i].issAddr, vecs[i].flush, vecs[i].ra0, vecs[i].ra1);
            checkOutput($sformatf("v%0d_d0", i), 64'(rd_data_o[31:0]), 64'(vecs[i].expD0));
            checkOutput($sformatf("v%0d_d1", i), 64'(rd_data_o[63:32]), 64'(vecs[i].expD1));
            checkOutput($sformatf("v%0d_busy", i), 64'(rd_busy_o), 64'(vecs[i].expBusy));
            checkOutput($sformatf("v%0d_ready", i), 64'(iss_ready_o), 64'(vecs[i].expReady));
            checkOutput($sformatf("v%0d_vec", i), 64'(busy_vec_o), 64'(vecs[i].expVec));
            tick();
        end

        // Register 6 is busy and 31 holds data; an asynchronous reset must wipe both at once.
        applyStimulus(1, 31, 32'hDEAD, 1, 0, 0, 31, 6);
        checkOutput("pre_rst_vec", 64'(busy_vec_o), 64'h40);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_rd31", 64'(rd_data_o[31:0]), 64'h0);
        checkOutput("mid_rst_busy", 64'(rd_busy_o), 64'h0);
        checkOutput("mid_rst_ready", 64'(iss_ready_o), 64'h0);
        checkOutput("mid_rst_vec", 64'(busy_vec_o), 64'h0);
        tick();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 31, 3);
        checkOutput("after_rst_rd31", 64'(rd_data_o[31:0]), 64'h0);
        checkOutput("after_rst_rd3", 64'(rd_data_o[63:32]), 64'h0);
        checkOutput("after_rst_vec", 64'(busy_vec_o), 64'h0);
        tick();

`ifdef REGFILE_SB_STALL_CNT_EN
        checkOutput("stall_start", 64'(stall_cnt_o), 64'h0);
        applyStimulus(0, 0, 0, 1, 8, 0, 0, 0);
        tick();
        checkOutput("stall_after_issue", 64'(stall_cnt_o), 64'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 8, 0, 0, 0);
            checkOutput($sformatf("stall_rej%0d_ready", i), 64'(iss_ready_o), 64'h0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_cnt3", 64'(stall_cnt_o), 64'h3);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_after_flush", 64'(stall_cnt_o), 64'h3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
